// File: rtl/flappy_pkg.sv
// Shared constants for the flappy obstacle path: playfield defaults, scroller state
// encodings and the LFSR seed/taps.
package flappy_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int PIPE_W_DEF   = 52;
    localparam int BIRD_X_DEF   = 320;
    localparam int SPEED_DEF    = 2;
    localparam int GAP_MIN_DEF  = 120;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_FROZEN = 2'd2
    } scroll_state_t;

    // x^8+x^6+x^5+x^4+1 maps onto register bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/flappy_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick the gap height of each new pipe.
module flappy_lfsr8
    import flappy_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    output logic [7:0] q
);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/obstacle_scroller.sv
// Scrolls one pipe leftward per frame tick, respawns it with a random gap and counts passes.
// Optional build macro OBSTACLE_SPEEDUP_EN makes the scroll step grow with the score.
module obstacle_scroller
    import flappy_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int PIPE_W   = PIPE_W_DEF,
    parameter int BIRD_X   = BIRD_X_DEF,
    parameter int SPEED    = SPEED_DEF,
    parameter int GAP_MIN  = GAP_MIN_DEF
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Frame_Tick,
    input  logic       Lose,
    input  logic       Ack,
    output logic [9:0] X_Edge,
    output logic [9:0] Y_Edge,
    output logic [7:0] Score,
    output logic       New_Pipe,
    output logic       Q_Idle,
    output logic       Q_Scroll,
    output logic       Q_Frozen
);

    localparam logic [9:0]  SCREEN_X  = 10'(SCREEN_W);
    localparam logic [9:0]  GAP_BASE  = 10'(GAP_MIN);
    localparam logic [10:0] PIPE_W_11 = 11'(PIPE_W);
    localparam logic [10:0] BIRD_X_11 = 11'(BIRD_X);

    scroll_state_t state, state_nxt;
    logic [7:0] lfsr_q;
    logic [9:0] x_nxt, y_nxt, spawn_y;
    logic [7:0] score_nxt;
    logic       passed_q, passed_nxt, new_pipe_nxt;
    logic [3:0] step;
    logic       pass_hit, wrap_hit;

    flappy_lfsr8 u_lfsr (
        .Clk   (Clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign spawn_y = GAP_BASE + {3'b000, lfsr_q[6:0]};

`ifdef OBSTACLE_SPEEDUP_EN
    logic [5:0] step_raw;
    assign step_raw = 6'(SPEED) + {1'b0, Score[7:3]};
    assign step     = (step_raw > 6'd15) ? 4'd15 : step_raw[3:0];
`else
    assign step = 4'(SPEED);
`endif

    // Pass test uses the pre-update X in 11 bits so X_Edge+PIPE_W cannot wrap
    assign pass_hit = ({1'b0, X_Edge} + PIPE_W_11) < BIRD_X_11;
    assign wrap_hit = X_Edge < {6'd0, step};

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        x_nxt        = X_Edge;
        y_nxt        = Y_Edge;
        score_nxt    = Score;
        passed_nxt   = passed_q;
        new_pipe_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt    = ST_SCROLL;
                    score_nxt    = 8'd0;
                    x_nxt        = SCREEN_X;
                    y_nxt        = spawn_y;
                    passed_nxt   = 1'b0;
                    new_pipe_nxt = 1'b1;
                end
            end
            ST_SCROLL: begin
                // Lose wins over the tick so the frozen frame shows the colliding position
                if (Lose) begin
                    state_nxt = ST_FROZEN;
                end else if (Frame_Tick) begin
                    if (!passed_q && pass_hit) begin
                        passed_nxt = 1'b1;
                        if (Score != 8'hFF) begin
                            score_nxt = Score + 8'd1;
                        end
                    end
                    if (wrap_hit) begin
                        x_nxt        = SCREEN_X;
                        y_nxt        = spawn_y;
                        passed_nxt   = 1'b0;
                        new_pipe_nxt = 1'b1;
                    end else begin
                        x_nxt = X_Edge - {6'd0, step};
                    end
                end
            end
            ST_FROZEN: begin
                if (Ack) begin
                    state_nxt = ST_IDLE;
                    x_nxt     = SCREEN_X;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            X_Edge   <= SCREEN_X;
            Y_Edge   <= GAP_BASE;
            Score    <= 8'd0;
            passed_q <= 1'b0;
            New_Pipe <= 1'b0;
        end else begin
            X_Edge   <= x_nxt;
            Y_Edge   <= y_nxt;
            Score    <= score_nxt;
            passed_q <= passed_nxt;
            New_Pipe <= new_pipe_nxt;
        end
    end

    assign Q_Idle   = (state == ST_IDLE);
    assign Q_Scroll = (state == ST_SCROLL);
    assign Q_Frozen = (state == ST_FROZEN);

endmodule
